// File: rtl/alu_req_sched.sv
// Two-requester round-robin front-end for a shared combinational ALU.
// Captures one op at a time, holds it for a per-function latency, returns a tagged result.

module alu_core #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         func,
  output logic [2*WIDTH-1:0] out,
  output logic               ovf
);
  always_comb begin
    out = '0;
    ovf = 1'b0;
    case (func)
      // ovf is the unsigned carry (add) or borrow (sub) out of the top bit
      2'b00: {ovf, out[WIDTH-1:0]} = {1'b0, a} + {1'b0, b};
      2'b01: {ovf, out[WIDTH-1:0]} = {1'b0, a} - {1'b0, b};
      2'b10: out = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      2'b11: if (b != '0) out = {a / b, a % b};
      default: out = '0;
    endcase
  end
endmodule

module alu_req_sched #(
  parameter int WIDTH      = 6,
  parameter int ADDSUB_LAT = 1,
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [1:0]         func0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  input  logic [1:0]         func1,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_out,
  output logic               rsp_ovf,
  output logic               rsp_err,
  input  logic               rsp_ready
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state;
  logic               rr;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [1:0]         op_func;
  logic [3:0]         cnt;

  logic               win;
  logic [WIDTH-1:0]   win_a;
  logic [WIDTH-1:0]   win_b;
  logic [1:0]         win_func;
  logic [2*WIDTH-1:0] alu_out;
  logic               alu_ovf;

  function automatic logic [3:0] lat_m1(input logic [1:0] f);
    case (f)
      2'b10:   lat_m1 = 4'(MUL_LAT - 1);
      2'b11:   lat_m1 = 4'(DIV_LAT - 1);
      default: lat_m1 = 4'(ADDSUB_LAT - 1);
    endcase
  endfunction

  // With both requesting, the rr pointer picks; otherwise the lone requester wins.
  always_comb begin
    win      = (req == 2'b11) ? rr : req[1];
    win_a    = win ? a1 : a0;
    win_b    = win ? b1 : b0;
    win_func = win ? func1 : func0;
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a    (op_a),
    .b    (op_b),
    .func (op_func),
    .out  (alu_out),
    .ovf  (alu_ovf)
  );

  // Response handshake: rsp_valid rises with the result and stays high with
  // rsp_id/out/ovf/err stable; the transfer completes on an edge with
  // rsp_valid & rsp_ready, and rsp_ready without rsp_valid has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_func   <= '0;
      cnt       <= '0;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      gnt <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            op_a    <= win_a;
            op_b    <= win_b;
            op_func <= win_func;
            rsp_id  <= win;
            rr      <= ~win;
            gnt     <= win ? 2'b10 : 2'b01;
            busy    <= 1'b1;
            // Divide-by-zero never reaches the ALU.
            if (win_func == 2'b11 && win_b == '0) begin
              state     <= DONE;
              cnt       <= '0;
              rsp_out   <= '0;
              rsp_ovf   <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
            end else begin
              state <= EXEC;
              cnt   <= lat_m1(win_func);
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_out   <= alu_out;
            rsp_ovf   <= alu_ovf;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_sched.sv
// Directed bench for alu_req_sched: single requests per function, stall,
// divide-by-zero, overflow, mid-EXEC reset and round-robin with both requesting.

module tb_alu_req_sched;
  localparam int WIDTH = 6;
  localparam int RW    = 2 * WIDTH;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [1:0]    func0, func1;
  logic [1:0]    gnt;
  logic          busy;
  logic          rsp_valid;
  logic          rsp_id;
  logic [RW-1:0] rsp_out;
  logic          rsp_ovf;
  logic          rsp_err;
  logic          rsp_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [RW:0] exp_q[$];

  alu_req_sched #(
    .WIDTH(WIDTH), .ADDSUB_LAT(1), .MUL_LAT(4), .DIV_LAT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a0(a0), .b0(b0), .func0(func0),
    .a1(a1), .b1(b1), .func1(func1),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int who, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] f, input string tag);
    int n;
    if (who == 0) begin
      a0 = a; b0 = b; func0 = f; req = 2'b01;
    end else begin
      a1 = a; b1 = b; func1 = f; req = 2'b10;
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == 2'b00 && n < 20);
    check({tag, "_gnt"}, 32'(gnt), (who == 0) ? 32'h1 : 32'h2);
    check({tag, "_busy"}, 32'(busy), 32'h1);
    req = 2'b00;
  endtask

  task automatic wait_rsp(input int lat, input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
  endtask

  task automatic check_rsp(input string tag, input logic id, input logic [RW-1:0] out,
                           input logic ovf, input logic err);
    check({tag, "_id"},  32'(rsp_id),  32'(id));
    check({tag, "_out"}, 32'(rsp_out), 32'(out));
    check({tag, "_ovf"}, 32'(rsp_ovf), 32'(ovf));
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
  endtask

  task automatic accept(input string tag);
    rsp_ready = 1'b1;
    tick();
    check({tag, "_acc_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_acc_busy"},  32'(busy),      32'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},   32'(gnt),       32'h0);
    check({tag, "_busy"},  32'(busy),      32'h0);
    check({tag, "_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_id"},    32'(rsp_id),    32'h0);
    check({tag, "_out"},   32'(rsp_out),   32'h0);
    check({tag, "_ovf"},   32'(rsp_ovf),   32'h0);
    check({tag, "_err"},   32'(rsp_err),   32'h0);
  endtask

  initial begin
    logic saw_valid;
    logic exp_id;
    logic prev_busy;
    int   grants, rsps, n;

    rst_n = 1'b0; req = 2'b00; rsp_ready = 1'b0;
    a0 = '0; b0 = '0; func0 = '0; a1 = '0; b1 = '0; func1 = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // add: 10 + 5
    rsp_ready = 1'b1;
    issue(0, 6'd10, 6'd5, 2'b00, "add");
    wait_rsp(1, "add");
    check("add_gnt_drop", 32'(gnt), 32'h0);
    check_rsp("add", 1'b0, 12'd15, 1'b0, 1'b0);
    accept("add");

    // mul: 7 * 9 from requester 1
    issue(1, 6'd7, 6'd9, 2'b10, "mul");
    wait_rsp(4, "mul");
    check_rsp("mul", 1'b1, 12'd63, 1'b0, 1'b0);
    accept("mul");
    check("mul_hold", 32'(rsp_out), 32'd63);

    // div: 45 / 7 = {6,3}, consumer stalls 5 cycles
    rsp_ready = 1'b0;
    issue(0, 6'd45, 6'd7, 2'b11, "div");
    wait_rsp(8, "div");
    check_rsp("div", 1'b0, 12'h183, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("div_stall_valid", 32'(rsp_valid), 32'h1);
      check("div_stall_out",   32'(rsp_out),   32'h183);
    end
    accept("div");

    // divide by zero: valid in the grant cycle
    issue(0, 6'd9, 6'd0, 2'b11, "dz");
    wait_rsp(0, "dz");
    check_rsp("dz", 1'b0, 12'd0, 1'b0, 1'b1);
    accept("dz");

    // 32 + 32 wraps to 0 with carry; 20 - 33 wraps to 51 with borrow
    issue(1, 6'd32, 6'd32, 2'b00, "addovf");
    wait_rsp(1, "addovf");
    check_rsp("addovf", 1'b1, 12'd0, 1'b1, 1'b0);
    accept("addovf");
    issue(0, 6'd20, 6'd33, 2'b01, "sub");
    wait_rsp(1, "sub");
    check_rsp("sub", 1'b0, 12'd51, 1'b1, 1'b0);
    accept("sub");

    // reset in the middle of a divide
    issue(0, 6'd45, 6'd7, 2'b11, "rstdiv");
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      tick();
      if (rsp_valid) saw_valid = 1'b1;
    end
    check("midrst_novalid", 32'(saw_valid), 32'h0);

    // both requesting for 4 ops: grants alternate starting at 0
    a0 = 6'd12; b0 = 6'd3; func0 = 2'b00;
    a1 = 6'd9;  b1 = 6'd4; func1 = 2'b01;
    req = 2'b11;
    grants = 0; rsps = 0; n = 0;
    exp_id = 1'b0;
    prev_busy = busy;
    while ((grants < 4 || rsps < 4) && n < 100) begin
      tick();
      n++;
      if (gnt != 2'b00) begin
        check("rr_gnt", 32'(gnt), exp_id ? 32'h2 : 32'h1);
        check("rr_gnt_idle", 32'(prev_busy), 32'h0);
        exp_q.push_back(exp_id ? {1'b1, 12'd5} : {1'b0, 12'd15});
        exp_id = ~exp_id;
        grants++;
        if (grants == 4) req = 2'b00;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rr_unexpected", 32'h1, 32'h0);
        else check("rr_rsp", 32'({rsp_id, rsp_out}), 32'(exp_q.pop_front()));
        rsps++;
      end
      prev_busy = busy;
    end
    check("rr_grants", 32'(grants), 32'd4);
    check("rr_rsps",   32'(rsps),   32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
